// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha20 core arbiter and its keystream serializer.
package chacha_pkg;

    localparam int C_KEY_W   = 256;
    localparam int C_NONCE_W = 96;
    localparam int C_CTR_W   = 32;
    localparam int C_BLOCK_W = 512;

    // Arbiter FSM encoding; plain constants keep the encoding visible to
    // older tools and scripts that probe the state register.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/chacha_core_arbiter_ks_serializer.sv
// Holds one 512-bit keystream block and plays it out as 32-bit AXI-Stream
// words to whichever channel currently owns the core.
module ks_serializer
    import chacha_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_BLOCK_WORDS = 16
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic                    i_load,
    input  logic [C_BLOCK_W-1:0]    i_block,
    input  logic                    i_active,
    input  logic                    i_chan,
    input  logic                    m0_axis_tready,
    input  logic                    m1_axis_tready,
    output logic                    m0_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0] m0_axis_tdata,
    output logic                    m0_axis_tlast,
    output logic                    m1_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0] m1_axis_tdata,
    output logic                    m1_axis_tlast,
    output logic                    o_last_hs
);

    localparam int C_IDX_W = $clog2(C_BLOCK_WORDS);

    logic [C_BLOCK_W-1:0]    buf_q;
    logic [C_IDX_W-1:0]      idx_q;
    logic [C_DATA_WIDTH-1:0] word;
    logic                    last_word;
    logic                    hs;

    assign word      = buf_q[int'(idx_q) * C_DATA_WIDTH +: C_DATA_WIDTH];
    assign last_word = (idx_q == C_IDX_W'(C_BLOCK_WORDS - 1));
    assign hs        = i_active & (i_chan ? m1_axis_tready : m0_axis_tready);
    assign o_last_hs = hs & last_word;

    // Capture a fresh block from the core, then step through it one accepted word at a time.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            buf_q <= '0;
            idx_q <= '0;
        end else if (i_load) begin
            buf_q <= i_block;
            idx_q <= '0;
        end else if (hs) begin
            idx_q <= idx_q + C_IDX_W'(1);
        end
    end

    // Only the owning channel ever sees tvalid; data is shared, tlast is gated per channel.
    always_comb begin
        m0_axis_tvalid = i_active & ~i_chan;
        m1_axis_tvalid = i_active &  i_chan;
        m0_axis_tdata  = word;
        m1_axis_tdata  = word;
        m0_axis_tlast  = m0_axis_tvalid & last_word;
        m1_axis_tlast  = m1_axis_tvalid & last_word;
    end

endmodule

// File: rtl/chacha_core_arbiter.sv
// Round-robin sharing of one ChaCha20 block core between the tx (ch0) and
// rx (ch1) keystream requesters.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE     | waiting for a request; ready is offered combinationally
//  START    | one-cycle start pulse to the core, inputs already latched
//  WAIT     | core running, inputs held; done captures the block
//  DRAIN    | block being streamed as 16 words to the granted channel
module chacha_core_arbiter
    import chacha_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_BLOCK_WORDS = 16
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic [1:0]              s_req_valid,
    output logic [1:0]              s_req_ready,
    input  logic [C_CTR_W-1:0]      i_req_counter0,
    input  logic [C_CTR_W-1:0]      i_req_counter1,
    input  logic [C_KEY_W-1:0]      i_key0,
    input  logic [C_KEY_W-1:0]      i_key1,
    input  logic [C_NONCE_W-1:0]    i_nonce0,
    input  logic [C_NONCE_W-1:0]    i_nonce1,
    output logic                    o_core_start,
    output logic [C_KEY_W-1:0]      o_core_key,
    output logic [C_NONCE_W-1:0]    o_core_nonce,
    output logic [C_CTR_W-1:0]      o_core_counter,
    input  logic                    i_core_done,
    input  logic [C_BLOCK_W-1:0]    i_core_block,
    output logic                    m0_axis_tvalid,
    input  logic                    m0_axis_tready,
    output logic [C_DATA_WIDTH-1:0] m0_axis_tdata,
    output logic                    m0_axis_tlast,
    output logic                    m1_axis_tvalid,
    input  logic                    m1_axis_tready,
    output logic [C_DATA_WIDTH-1:0] m1_axis_tdata,
    output logic                    m1_axis_tlast,
    output logic                    o_busy,
    output logic                    o_grant
);

    state_t               state_q;
    logic                 last_grant_q;
    logic                 grant_q;
    logic [C_KEY_W-1:0]   key_q;
    logic [C_NONCE_W-1:0] nonce_q;
    logic [C_CTR_W-1:0]   ctr_q;

    logic                 sel;
    logic [1:0]           ready;
    logic                 accept;
    logic                 load;
    logic                 last_hs;

    // Pick the requester: a lone requester wins, contention goes to whoever was not served last.
    // Reset masks ready so a request coincident with reset is never accepted.
    always_comb begin
        sel   = (&s_req_valid) ? ~last_grant_q : s_req_valid[1];
        ready = '0;
        if (state_q == ST_IDLE && !i_areset) begin
            ready[sel] = s_req_valid[sel];
        end
        accept = |(ready & s_req_valid);
    end

    // Sequence the core and latch the accepted channel's inputs.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            key_q        <= '0;
            nonce_q      <= '0;
            ctr_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        grant_q <= sel;
                        key_q   <= sel ? i_key1 : i_key0;
                        nonce_q <= sel ? i_nonce1 : i_nonce0;
                        ctr_q   <= sel ? i_req_counter1 : i_req_counter0;
                        state_q <= ST_START;
                    end
                end
                ST_START: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (i_core_done) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_hs) begin
                        last_grant_q <= grant_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A done pulse only matters while the core is actually running for us.
    assign load = (state_q == ST_WAIT) & i_core_done;

    ks_serializer #(
        .C_DATA_WIDTH  (C_DATA_WIDTH),
        .C_BLOCK_WORDS (C_BLOCK_WORDS)
    ) u_ks_serializer (
        .i_aclk         (i_aclk),
        .i_areset       (i_areset),
        .i_load         (load),
        .i_block        (i_core_block),
        .i_active       (state_q == ST_DRAIN),
        .i_chan         (grant_q),
        .m0_axis_tready (m0_axis_tready),
        .m1_axis_tready (m1_axis_tready),
        .m0_axis_tvalid (m0_axis_tvalid),
        .m0_axis_tdata  (m0_axis_tdata),
        .m0_axis_tlast  (m0_axis_tlast),
        .m1_axis_tvalid (m1_axis_tvalid),
        .m1_axis_tdata  (m1_axis_tdata),
        .m1_axis_tlast  (m1_axis_tlast),
        .o_last_hs      (last_hs)
    );

    assign s_req_ready    = ready;
    assign o_core_start   = (state_q == ST_START);
    assign o_core_key     = key_q;
    assign o_core_nonce   = nonce_q;
    assign o_core_counter = ctr_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_grant        = grant_q;

endmodule

// File: tb/tb_chacha_core_arbiter.sv
// Scoreboard bench for chacha_core_arbiter with a fixed-latency core model.
module tb_chacha_core_arbiter;

    logic         i_aclk;
    logic         i_areset;
    logic [1:0]   s_req_valid;
    logic [1:0]   s_req_ready;
    logic [31:0]  i_req_counter0, i_req_counter1;
    logic [255:0] i_key0, i_key1;
    logic [95:0]  i_nonce0, i_nonce1;
    logic         o_core_start;
    logic [255:0] o_core_key;
    logic [95:0]  o_core_nonce;
    logic [31:0]  o_core_counter;
    logic         i_core_done;
    logic [511:0] i_core_block;
    logic         m0_axis_tvalid, m0_axis_tready, m0_axis_tlast;
    logic         m1_axis_tvalid, m1_axis_tready, m1_axis_tlast;
    logic [31:0]  m0_axis_tdata, m1_axis_tdata;
    logic         o_busy, o_grant;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp0[$];
    logic [32:0] exp1[$];
    logic        exp_grant[$];

    localparam logic [255:0] KEY0   = {8{32'hA5A5_0000}};
    localparam logic [255:0] KEY1   = {8{32'h5A5A_1111}};
    localparam logic [95:0]  NONCE0 = {3{32'hC0DE_0000}};
    localparam logic [95:0]  NONCE1 = {3{32'hBEEF_1111}};

    chacha_core_arbiter dut (
        .i_aclk         (i_aclk),
        .i_areset       (i_areset),
        .s_req_valid    (s_req_valid),
        .s_req_ready    (s_req_ready),
        .i_req_counter0 (i_req_counter0),
        .i_req_counter1 (i_req_counter1),
        .i_key0         (i_key0),
        .i_key1         (i_key1),
        .i_nonce0       (i_nonce0),
        .i_nonce1       (i_nonce1),
        .o_core_start   (o_core_start),
        .o_core_key     (o_core_key),
        .o_core_nonce   (o_core_nonce),
        .o_core_counter (o_core_counter),
        .i_core_done    (i_core_done),
        .i_core_block   (i_core_block),
        .m0_axis_tvalid (m0_axis_tvalid),
        .m0_axis_tready (m0_axis_tready),
        .m0_axis_tdata  (m0_axis_tdata),
        .m0_axis_tlast  (m0_axis_tlast),
        .m1_axis_tvalid (m1_axis_tvalid),
        .m1_axis_tready (m1_axis_tready),
        .m1_axis_tdata  (m1_axis_tdata),
        .m1_axis_tlast  (m1_axis_tlast),
        .o_busy         (o_busy),
        .o_grant        (o_grant)
    );

    initial begin
        i_aclk = 1'b0;
        forever #5 i_aclk = ~i_aclk;
    end

    // Core model: 20-cycle latency, word i = {counter[15:0], i[15:0]}; stray pulses on request.
    int          core_cnt  = 0;
    logic [31:0] core_ctr  = '0;
    bit          stray_req = 0;

    function automatic logic [511:0] make_block(input logic [31:0] ctr);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = {ctr[15:0], 16'(i)};
        return b;
    endfunction

    always @(posedge i_aclk) begin
        #1;
        i_core_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                i_core_done  = 1'b1;
                i_core_block = make_block(core_ctr);
            end
        end
        if (o_core_start) begin
            core_cnt = 20;
            core_ctr = o_core_counter;
        end
        if (stray_req) begin
            i_core_done  = 1'b1;
            i_core_block = make_block(32'h0000_DEAD);
            stray_req    = 0;
        end
    end

    // Output monitor: pops the scoreboard on every handshake, checks stall stability and grants.
    bit          prev_stall0 = 0, prev_stall1 = 0;
    logic [32:0] prev_w0, prev_w1;

    always @(negedge i_aclk) begin
        logic [32:0] e;
        if (m0_axis_tvalid) begin
            if (prev_stall0) begin
                n_checks++;
                if ({m0_axis_tlast, m0_axis_tdata} !== prev_w0) begin
                    n_fail++;
                    $display("FAIL m0_stall_hold: got %h required %h", {m0_axis_tlast, m0_axis_tdata}, prev_w0);
                end
            end
            if (m0_axis_tready) begin
                n_checks++;
                if (exp0.size() == 0) begin
                    n_fail++;
                    $display("FAIL m0_unexpected_word: got %h with nothing expected", m0_axis_tdata);
                end else begin
                    e = exp0.pop_front();
                    if ({m0_axis_tlast, m0_axis_tdata} !== e) begin
                        n_fail++;
                        $display("FAIL m0_word: got last=%b data=%h required last=%b data=%h",
                                 m0_axis_tlast, m0_axis_tdata, e[32], e[31:0]);
                    end
                end
            end
            prev_stall0 = !m0_axis_tready;
            prev_w0     = {m0_axis_tlast, m0_axis_tdata};
        end else begin
            prev_stall0 = 0;
        end
        if (m1_axis_tvalid) begin
            if (prev_stall1) begin
                n_checks++;
                if ({m1_axis_tlast, m1_axis_tdata} !== prev_w1) begin
                    n_fail++;
                    $display("FAIL m1_stall_hold: got %h required %h", {m1_axis_tlast, m1_axis_tdata}, prev_w1);
                end
            end
            if (m1_axis_tready) begin
                n_checks++;
                if (exp1.size() == 0) begin
                    n_fail++;
                    $display("FAIL m1_unexpected_word: got %h with nothing expected", m1_axis_tdata);
                end else begin
                    e = exp1.pop_front();
                    if ({m1_axis_tlast, m1_axis_tdata} !== e) begin
                        n_fail++;
                        $display("FAIL m1_word: got last=%b data=%h required last=%b data=%h",
                                 m1_axis_tlast, m1_axis_tdata, e[32], e[31:0]);
                    end
                end
            end
            prev_stall1 = !m1_axis_tready;
            prev_w1     = {m1_axis_tlast, m1_axis_tdata};
        end else begin
            prev_stall1 = 0;
        end
        if (m0_axis_tvalid && m1_axis_tvalid) begin
            n_checks++;
            n_fail++;
            $display("FAIL both_tvalid: got m0=1 m1=1 required one at most");
        end
        if (o_core_start) begin
            n_checks++;
            if (exp_grant.size() == 0) begin
                n_fail++;
                $display("FAIL grant_unexpected: got start with grant %b, none expected", o_grant);
            end else begin
                e[0] = exp_grant.pop_front();
                if (o_grant !== e[0]) begin
                    n_fail++;
                    $display("FAIL grant_order: got %b required %b", o_grant, e[0]);
                end
                n_checks++;
                if (o_core_key !== (e[0] ? KEY1 : KEY0) || o_core_nonce !== (e[0] ? NONCE1 : NONCE0)) begin
                    n_fail++;
                    $display("FAIL core_key_nonce: got key %h nonce %h for channel %b", o_core_key, o_core_nonce, e[0]);
                end
            end
        end
    end

    task automatic push_words(input bit ch, input logic [31:0] ctr);
        for (int i = 0; i < 16; i++) begin
            if (ch) exp1.push_back({i == 15, ctr[15:0], 16'(i)});
            else    exp0.push_back({i == 15, ctr[15:0], 16'(i)});
        end
    endtask

    task automatic reset_dut();
        @(posedge i_aclk); #1;
        i_areset = 1'b1;
        @(posedge i_aclk); #1;
        i_areset = 1'b0;
    endtask

    // Drives n0/n1 back-to-back requests per channel (valid held continuously) until all drained.
    task automatic run_reqs(input int n0, input int n1, input logic [31:0] c0, input logic [31:0] c1,
                            input bit bp, input bit stray);
        int          rem0 = n0;
        int          rem1 = n1;
        logic [31:0] k0   = c0;
        logic [31:0] k1   = c1;
        logic [1:0]  acc;
        bit          fired = 0;
        int          cyc   = 0;
        @(posedge i_aclk); #1;
        if (rem0 > 0) begin i_req_counter0 = k0; push_words(0, k0); s_req_valid[0] = 1'b1; end
        if (rem1 > 0) begin i_req_counter1 = k1; push_words(1, k1); s_req_valid[1] = 1'b1; end
        while ((rem0 > 0 || rem1 > 0 || o_busy || exp0.size() != 0 || exp1.size() != 0) && cyc < 600) begin
            @(negedge i_aclk);
            acc = s_req_valid & s_req_ready;
            if (stray && !fired && m0_axis_tvalid && exp0.size() == 10) begin
                stray_req = 1;
                fired     = 1;
            end
            @(posedge i_aclk); #1;
            cyc++;
            if (bp) m0_axis_tready = (cyc % 3 != 0);
            if (acc[0]) begin
                rem0--;
                if (rem0 > 0) begin k0++; i_req_counter0 = k0; push_words(0, k0); end
                else s_req_valid[0] = 1'b0;
            end
            if (acc[1]) begin
                rem1--;
                if (rem1 > 0) begin k1++; i_req_counter1 = k1; push_words(1, k1); end
                else s_req_valid[1] = 1'b0;
            end
        end
        m0_axis_tready = 1'b1;
        n_checks++;
        if (cyc >= 600) begin
            n_fail++;
            $display("FAIL run_timeout: got %0d cycles, left ch0=%0d ch1=%0d words %0d/%0d required completion",
                     cyc, rem0, rem1, exp0.size(), exp1.size());
            exp0.delete(); exp1.delete(); exp_grant.delete();
            s_req_valid = '0;
        end
    endtask

    task automatic test_reset();
        i_areset    = 1'b1;
        s_req_valid = 2'b11;
        repeat (3) @(posedge i_aclk);
        @(negedge i_aclk);
        n_checks++;
        if (s_req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b required 00", s_req_ready); end
        n_checks++;
        if ({o_busy, o_grant, o_core_start} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got busy/grant/start %b required 000", {o_busy, o_grant, o_core_start});
        end
        n_checks++;
        if ({m0_axis_tvalid, m0_axis_tlast, m1_axis_tvalid, m1_axis_tlast} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_axis: got %b required 0000", {m0_axis_tvalid, m0_axis_tlast, m1_axis_tvalid, m1_axis_tlast});
        end
        n_checks++;
        if (o_core_key !== '0 || o_core_nonce !== '0 || o_core_counter !== '0) begin
            n_fail++; $display("FAIL reset_core_regs: got ctr %h required 0 with zero key/nonce", o_core_counter);
        end
        @(posedge i_aclk); #1;
        s_req_valid = 2'b00;
        i_areset    = 1'b0;
    endtask

    task automatic test_ch0_alone();
        int  w;
        bit  m1_seen = 0;
        @(posedge i_aclk); #1;
        push_words(0, 32'h1);
        exp_grant.push_back(1'b0);
        i_req_counter0 = 32'h1;
        s_req_valid    = 2'b01;
        @(negedge i_aclk);
        n_checks++;
        if (s_req_ready !== 2'b01 || o_core_start !== 1'b0) begin
            n_fail++; $display("FAIL ch0_ready_same_cycle: got ready %b start %b required 01 0", s_req_ready, o_core_start);
        end
        @(posedge i_aclk); #1;
        s_req_valid = 2'b00;
        @(negedge i_aclk);
        n_checks++;
        if (o_core_start !== 1'b1 || o_core_counter !== 32'h1 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL ch0_start_pulse: got start %b ctr %h busy %b required 1 00000001 1", o_core_start, o_core_counter, o_busy);
        end
        @(negedge i_aclk);
        n_checks++;
        if (o_core_start !== 1'b0) begin n_fail++; $display("FAIL ch0_start_width: got %b required 0", o_core_start); end
        w = 0;
        while (!i_core_done && w < 40) begin @(negedge i_aclk); w++; end
        n_checks++;
        if (w >= 40) begin n_fail++; $display("FAIL ch0_core_done_timeout: got no done in %0d cycles", w); end
        for (int k = 1; k <= 16; k++) begin
            @(negedge i_aclk);
            if (m1_axis_tvalid) m1_seen = 1;
            n_checks++;
            if (m0_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL ch0_word_timing: got tvalid %b at done+%0d required 1", m0_axis_tvalid, k); end
        end
        @(negedge i_aclk);
        n_checks++;
        if (o_busy !== 1'b0 || m0_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL ch0_idle_after: got busy %b tvalid %b at done+17 required 0 0", o_busy, m0_axis_tvalid);
        end
        n_checks++;
        if (m1_seen || exp0.size() != 0) begin
            n_fail++; $display("FAIL ch0_isolation: got m1 seen %b, %0d words left required 0 0", m1_seen, exp0.size());
        end
    endtask

    task automatic test_contention();
        reset_dut();
        exp_grant.push_back(1'b0);
        exp_grant.push_back(1'b1);
        run_reqs(1, 1, 32'h5, 32'h9, 0, 0);
        n_checks++;
        if (exp_grant.size() != 0) begin n_fail++; $display("FAIL contention_grants: got %0d grants missing required 0", exp_grant.size()); end
    endtask

    task automatic test_round_robin();
        exp_grant.push_back(1'b0);
        exp_grant.push_back(1'b1);
        exp_grant.push_back(1'b0);
        exp_grant.push_back(1'b1);
        run_reqs(2, 2, 32'h10, 32'h20, 0, 0);
        n_checks++;
        if (exp_grant.size() != 0) begin n_fail++; $display("FAIL rr_grants: got %0d grants missing required 0", exp_grant.size()); end
    endtask

    task automatic test_backpressure();
        exp_grant.push_back(1'b0);
        run_reqs(1, 0, 32'h33, 32'h0, 1, 0);
    endtask

    task automatic test_reset_during_wait();
        int seen = 0;
        exp_grant.push_back(1'b1);
        @(posedge i_aclk); #1;
        i_req_counter1 = 32'h7;
        s_req_valid    = 2'b10;
        @(posedge i_aclk); #1;
        s_req_valid = 2'b00;
        repeat (5) @(posedge i_aclk);
        #1;
        i_areset = 1'b1;
        @(posedge i_aclk); #1;
        i_areset = 1'b0;
        @(negedge i_aclk);
        n_checks++;
        if ({o_busy, o_grant, o_core_start, m0_axis_tvalid, m1_axis_tvalid} !== 5'b00000) begin
            n_fail++; $display("FAIL rst_wait_outputs: got busy/grant/start/tv0/tv1 %b required 00000",
                               {o_busy, o_grant, o_core_start, m0_axis_tvalid, m1_axis_tvalid});
        end
        n_checks++;
        if (o_core_counter !== '0 || o_core_key !== '0 || o_core_nonce !== '0) begin
            n_fail++; $display("FAIL rst_wait_core_regs: got ctr %h required 0 with zero key/nonce", o_core_counter);
        end
        repeat (30) begin
            @(negedge i_aclk);
            if (m0_axis_tvalid || m1_axis_tvalid || o_busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rst_wait_late_done: got %0d active cycles required 0", seen); end
        exp_grant.push_back(1'b1);
        run_reqs(0, 1, 32'h0, 32'h2, 0, 0);
    endtask

    task automatic test_stray_done();
        @(negedge i_aclk);
        stray_req = 1;
        @(negedge i_aclk);
        @(negedge i_aclk);
        n_checks++;
        if (o_busy !== 1'b0 || m0_axis_tvalid !== 1'b0 || m1_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL stray_idle: got busy %b tv0 %b tv1 %b required 0 0 0", o_busy, m0_axis_tvalid, m1_axis_tvalid);
        end
        exp_grant.push_back(1'b0);
        run_reqs(1, 0, 32'h3, 32'h0, 0, 1);
    endtask

    initial begin
        i_areset       = 1'b1;
        s_req_valid    = 2'b00;
        i_req_counter0 = '0;
        i_req_counter1 = '0;
        i_key0         = KEY0;
        i_key1         = KEY1;
        i_nonce0       = NONCE0;
        i_nonce1       = NONCE1;
        i_core_done    = 1'b0;
        i_core_block   = '0;
        m0_axis_tready = 1'b1;
        m1_axis_tready = 1'b1;

        test_reset();
        test_ch0_alone();
        test_contention();
        test_round_robin();
        test_backpressure();
        test_reset_during_wait();
        test_stray_done();

        repeat (3) @(posedge i_aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
